// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer: word/select widths,
// FSM state encoding and the scan start/end indices for either bit order.
package mux_scan_pkg;

  localparam int WIDTH = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [SEL_W-1:0] START_IDX(input bit msb_first);
    return msb_first ? SEL_W'(WIDTH - 1) : '0;
  endfunction

  function automatic logic [SEL_W-1:0] END_IDX(input bit msb_first);
    return msb_first ? '0 : SEL_W'(WIDTH - 1);
  endfunction

endpackage

// File: rtl/mux25.sv
// 16:1 combinational bit selector that sits beside the sequencer at the parent level.
module mux25 (
  input  logic [15:0] in,
  input  logic [3:0]  sel,
  output logic        out
);

  assign out = in[sel];

endmodule

// File: rtl/mux_scan_sequencer.sv
// Framed parallel-to-serial front end for the 16:1 selector: holds an accepted word
// on the selector bus and walks the select through all channels under valid/ready.
module mux_scan_sequencer #(
  parameter int WIDTH     = 16,
  parameter int SEL_W     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] mux_in,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_bit,
  output logic             ser_last,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  import mux_scan_pkg::*;

  localparam logic [SEL_W-1:0] START = SEL_W'(START_IDX(MSB_FIRST));
  localparam logic [SEL_W-1:0] STOP  = SEL_W'(END_IDX(MSB_FIRST));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mux_in_q, mux_in_d;
  logic [SEL_W-1:0] mux_sel_q, mux_sel_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             last_beat;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mux_in_q    <= '0;
      mux_sel_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mux_in_q    <= mux_in_d;
      mux_sel_q   <= mux_sel_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign last_beat = (state_q == RUN) && (mux_sel_q == STOP);
  // Gated by rst_n so every output reads low while reset is held.
  assign in_ready  = rst_n && ((state_q == IDLE) || (last_beat && ser_ready));
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    mux_in_d    = mux_in_q;
    mux_sel_d   = mux_sel_q;
    frame_cnt_d = frame_cnt_q;
    if (state_q == RUN && ser_ready) begin
      if (last_beat) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = IDLE;
      end else if (MSB_FIRST) begin
        mux_sel_d = mux_sel_q - SEL_W'(1);
      end else begin
        mux_sel_d = mux_sel_q + SEL_W'(1);
      end
    end
    // A load on the final beat overrides the return to IDLE: no bubble between frames.
    if (accept) begin
      mux_in_d  = in_data;
      mux_sel_d = START;
      state_d   = RUN;
    end
  end

  assign mux_in    = mux_in_q;
  assign mux_sel   = mux_sel_q;
  assign ser_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign ser_last  = last_beat;
  assign ser_bit   = mux_out;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomised bench for mux_scan_sequencer (LSB-first and MSB-first instances) against a
// word/beat-level reference model.
module tb_mux_scan_sequencer;

  typedef struct packed {
    logic        rdy;
    logic        vld;
    logic        sbit;
    logic        last;
    logic        bsy;
    logic [3:0]  sel;
    logic [15:0] word;
    logic [7:0]  cnt;
  } snap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid  [2];
  logic        ser_ready [2];
  logic [15:0] in_data   [2];
  logic        in_ready  [2];
  logic        ser_valid [2];
  logic        ser_bit   [2];
  logic        ser_last  [2];
  logic        busy      [2];
  logic        mux_out   [2];
  logic [15:0] mux_in    [2];
  logic [3:0]  mux_sel   [2];
  logic [7:0]  frame_cnt [2];

  mux_scan_sequencer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .mux_in(mux_in[0]), .mux_sel(mux_sel[0]), .mux_out(mux_out[0]),
    .ser_valid(ser_valid[0]), .ser_ready(ser_ready[0]), .ser_bit(ser_bit[0]),
    .ser_last(ser_last[0]), .busy(busy[0]), .frame_cnt(frame_cnt[0])
  );
  mux25 sel_lsb (.in(mux_in[0]), .sel(mux_sel[0]), .out(mux_out[0]));

  mux_scan_sequencer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .mux_in(mux_in[1]), .mux_sel(mux_sel[1]), .mux_out(mux_out[1]),
    .ser_valid(ser_valid[1]), .ser_ready(ser_ready[1]), .ser_bit(ser_bit[1]),
    .ser_last(ser_last[1]), .busy(busy[1]), .frame_cnt(frame_cnt[1])
  );
  mux25 sel_msb (.in(mux_in[1]), .sel(mux_sel[1]), .out(mux_out[1]));

  int tests = 0;
  int fails = 0;

  // Reference model: per instance, the word in flight and how many beats were taken.
  bit          m_idle [2];
  logic [15:0] m_word [2];
  int          m_pos  [2];
  int          m_sel  [2];
  int          m_cnt  [2];

  snap_t obs_s, exp_s;
  bit    acc_beat, acc_bit;

  function automatic int idx_of(int u, int pos);
    return (u == 1) ? 15 - pos : pos;
  endfunction

  function automatic bit m_ready(int u, bit rdy);
    return m_idle[u] || (m_pos[u] == 15 && rdy);
  endfunction

  function automatic snap_t observe(int u);
    snap_t s;
    s.rdy = in_ready[u]; s.vld = ser_valid[u]; s.sbit = ser_bit[u]; s.last = ser_last[u];
    s.bsy = busy[u]; s.sel = mux_sel[u]; s.word = mux_in[u]; s.cnt = frame_cnt[u];
    return s;
  endfunction

  function automatic snap_t expect_now(int u, bit rdy);
    snap_t s;
    s.rdy  = rst_n && m_ready(u, rdy);
    s.vld  = !m_idle[u];
    s.bsy  = !m_idle[u];
    s.last = !m_idle[u] && (m_pos[u] == 15);
    s.sel  = 4'(m_sel[u]);
    s.word = m_word[u];
    s.sbit = m_word[u][m_sel[u]];
    s.cnt  = 8'(m_cnt[u]);
    return s;
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_idle[u] = 1'b1; m_word[u] = '0; m_pos[u] = 0; m_sel[u] = 0; m_cnt[u] = 0;
    end
  endfunction

  // One clock: drive at negedge, sample 1ns later, advance the model across the posedge.
  task automatic step(input int u, input bit vin, input logic [15:0] d, input bit rdy);
    @(negedge clk);
    in_valid[u] = vin; in_data[u] = d; ser_ready[u] = rdy;
    #1;
    obs_s = observe(u);
    exp_s = expect_now(u, rdy);
    acc_beat = !m_idle[u] && rdy;
    acc_bit  = m_word[u][m_sel[u]];
    if (acc_beat) begin
      if (m_pos[u] == 15) begin
        m_cnt[u] = (m_cnt[u] + 1) % 256; m_idle[u] = 1'b1;
      end else begin
        m_pos[u]++; m_sel[u] = idx_of(u, m_pos[u]);
      end
    end
    if (exp_s.rdy && vin) begin
      m_word[u] = d; m_idle[u] = 1'b0; m_pos[u] = 0; m_sel[u] = idx_of(u, 0);
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin in_valid[u] = 1'b0; ser_ready[u] = 1'b0; end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int u = 0; u < 2; u++) begin
      obs_s = observe(u);
      exp_s = expect_now(u, 1'b0);
      tests++;
      if (obs_s !== exp_s) begin
        fails++; $display("FAIL reset_u%0d got %h want %h", u, obs_s, exp_s);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int u = 0; u < 2; u++) begin
      step(u, 1'b0, 16'h0, 1'b0);
      tests++;
      if (obs_s !== exp_s || obs_s.rdy !== 1'b1) begin
        fails++; $display("FAIL post_reset_u%0d got %h want %h", u, obs_s, exp_s);
      end
    end
  endtask

  // Single frame on one instance with ser_ready=1; bits collected by channel index.
  task automatic test_frame(input int u, input logic [15:0] w, input string name);
    logic [15:0] got;
    int beats, start_cnt;
    got = '0; beats = 0; start_cnt = m_cnt[u];
    step(u, 1'b1, w, 1'b1);
    tests++;
    if (obs_s !== exp_s) begin fails++; $display("FAIL %s_load got %h want %h", name, obs_s, exp_s); end
    for (int c = 0; c < 40 && !m_idle[u]; c++) begin
      step(u, 1'b0, 16'h0, 1'b1);
      tests++;
      if (obs_s !== exp_s) begin fails++; $display("FAIL %s_beat%0d got %h want %h", name, beats, obs_s, exp_s); end
      if (acc_beat) begin got[idx_of(u, beats)] = obs_s.sbit; beats++; end
    end
    tests++;
    if (got !== w || beats != 16) begin
      fails++; $display("FAIL %s_stream got %h/%0d beats want %h/16", name, got, beats, w);
    end
    step(u, 1'b0, 16'h0, 1'b0);
    tests++;
    if (obs_s.cnt !== 8'(start_cnt + 1)) begin
      fails++; $display("FAIL %s_frame_cnt got %0d want %0d", name, obs_s.cnt, start_cnt + 1);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] w, got;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int beats, c;
    w = 16'($urandom); got = '0; beats = 0;
    step(0, 1'b1, w, 1'b1);
    c = 0;
    while (!m_idle[0] && c < 200) begin
      step(0, 1'b0, 16'($urandom), pat[c % 4]);
      tests++;
      if (obs_s !== exp_s) begin fails++; $display("FAIL bp_cyc%0d got %h want %h", c, obs_s, exp_s); end
      if (acc_beat) begin got[beats % 16] = obs_s.sbit; beats++; end
      c++;
    end
    tests++;
    if (got !== w || beats != 16) begin
      fails++; $display("FAIL bp_stream got %h/%0d beats want %h/16", got, beats, w);
    end
  endtask

  task automatic test_back_to_back();
    int loaded, steps, cnt0;
    loaded = 0; steps = 0; cnt0 = m_cnt[0];
    while ((loaded < 2 || !m_idle[0]) && steps < 100) begin
      step(0, loaded < 2, (loaded == 0) ? 16'hFFFF : 16'h0001, 1'b1);
      if (exp_s.rdy && loaded < 2) loaded++;
      tests++;
      if (obs_s !== exp_s) begin fails++; $display("FAIL b2b_cyc%0d got %h want %h", steps, obs_s, exp_s); end
      steps++;
    end
    step(0, 1'b0, 16'h0, 1'b0);
    tests++;
    if (steps != 33 || obs_s.cnt !== 8'(cnt0 + 2)) begin
      fails++; $display("FAIL b2b_timing got %0d cycles cnt %0d want 33 cycles cnt %0d", steps, obs_s.cnt, cnt0 + 2);
    end
  endtask

  task automatic test_reset_midframe();
    int beats;
    beats = 0;
    step(0, 1'b1, 16'($urandom), 1'b1);
    while (beats < 6) begin step(0, 1'b0, 16'h0, 1'b1); beats++; end
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    obs_s = observe(0);
    tests++;
    if (obs_s.vld !== 1'b0 || obs_s.bsy !== 1'b0 || obs_s.sel !== 4'd0 || obs_s.cnt !== 8'd0 || obs_s.rdy !== 1'b0) begin
      fails++; $display("FAIL midframe_reset got %h want vld/busy/sel/cnt/rdy all 0", obs_s);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1'b0, 16'h0, 1'b1);
    tests++;
    if (obs_s !== exp_s || obs_s.rdy !== 1'b1) begin
      fails++; $display("FAIL midframe_release got %h want %h", obs_s, exp_s);
    end
  endtask

  task automatic test_wrap();
    int loaded, c;
    bit rdy;
    loaded = 0; c = 0;
    while ((loaded < 256 || !m_idle[0]) && c < 20000) begin
      rdy = ($urandom_range(0, 3) != 0);
      if (m_ready(0, rdy)) begin
        step(0, loaded < 256, 16'h0000, rdy);
        if (loaded < 256) loaded++;
      end else begin
        step(0, 1'b1, 16'($urandom), rdy);
      end
      tests++;
      if (obs_s !== exp_s) begin fails++; $display("FAIL wrap_cyc%0d got %h want %h", c, obs_s, exp_s); end
      c++;
    end
    step(0, 1'b0, 16'h0, 1'b0);
    tests++;
    if (obs_s.cnt !== 8'd0 || c >= 20000) begin
      fails++; $display("FAIL wrap_cnt got %0d after %0d cycles want 0", obs_s.cnt, c);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      step(0, $urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 2) != 0);
      tests++;
      if (obs_s !== exp_s) begin fails++; $display("FAIL rand_cyc%0d got %h want %h", c, obs_s, exp_s); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; ser_ready[u] = 1'b0; in_data[u] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_frame(0, 16'hA5C3, "lsb_a5c3");
    test_frame(1, 16'hA5C3, "msb_a5c3");
    test_backpressure();
    test_back_to_back();
    test_random();
    do_reset();
    test_reset_midframe();
    do_reset();
    test_wrap();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
